// File: rtl/nmos_cmp_seq.sv
`default_nettype none
// ============================================================================
//  Module      : nmos_cmp_seq
//  Description : Four-slot double-buffered position comparator driven by a
//                phase-1 strobed position counter.
//
//                Writes land in a per-slot stage register and are marked
//                pending. Each PHI1 strobe copies every pending stage value
//                into its active register and advances the counter. In the
//                cycle after a PHI1, each active value is compared with the
//                freshly updated counter. The result is registered into a
//                one-CLK MATCH pulse per slot.
//
//  Parameters  : HMAX    - last counter value before wrap to 0 (1..510)
//
//  Ports       : CLK     in   main clock, all state on rising edge
//                RST     in   asynchronous active-high reset
//                PHI1    in   phase-1 strobe, one CLK wide
//                WR_STB  in   write request for slot WR_ADDR
//                WR_ADDR in   [1:0] slot select
//                DB      in   [8:0] position, [9] slot enable
//                CNT_CLR in   sticky counter-clear request (taken at PHI1)
//                CNT     out  [8:0] running position counter
//                MATCH   out  [3:0] registered one-CLK match pulse per slot
//                BUSY    out  high while any staged write awaits transfer
//
//  Build option: CMP_SLOT_ENABLE_EN - when defined, DB[9] is staged with the
//                position and a slot only matches when its active enable is
//                set. When undefined, DB[9] is ignored and every slot is
//                always enabled.
//
//  Revision    : 1.0 - initial release
// ============================================================================

module nmos_cmp_seq #(
  parameter logic [8:0] HMAX = 9'd454
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PHI1,
  input  logic       WR_STB,
  input  logic [1:0] WR_ADDR,
  input  logic [9:0] DB,
  input  logic       CNT_CLR,
  output logic [8:0] CNT,
  output logic [3:0] MATCH,
  output logic       BUSY
);

  localparam int         NUM_SLOTS = 4;
  // Reset/idle position. The counter never exceeds HMAX (at most 510), so a
  // slot holding this value can never match.
  localparam logic [8:0] IDLE_POS  = 9'h1FF;

  // --------------------------------------------------------------------------
  // Slot storage
  // --------------------------------------------------------------------------
  logic [8:0]           stage_pos  [NUM_SLOTS];
  logic [8:0]           active_pos [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] pending;
  logic [NUM_SLOTS-1:0] pending_nxt;
  logic [NUM_SLOTS-1:0] wr_hit;
  logic [NUM_SLOTS-1:0] transfer;
  logic [NUM_SLOTS-1:0] slot_en;

  // Counter / evaluation state
  logic                 clr_req;
  logic                 eval;
  logic [8:0]           cnt_q;
  logic [NUM_SLOTS-1:0] match_q;
  logic [NUM_SLOTS-1:0] match_nxt;
  logic                 busy_q;

  // One-hot decode of the write target.
  always_comb begin
    wr_hit = '0;
    if (WR_STB) begin
      wr_hit = 4'b0001 << WR_ADDR;
    end
  end

  // A PHI1 moves every slot that was pending before this edge. A write in
  // the same cycle only affects the stage register, so the transfer always
  // sees the pre-write stage value.
  always_comb begin
    transfer = '0;
    if (PHI1) begin
      transfer = pending;
    end
  end

  // The written slot is pending after the edge regardless of PHI1; other
  // slots stay pending only when no PHI1 drains them.
  always_comb begin
    pending_nxt = wr_hit | (pending & ~transfer);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stage_pos[i]  <= IDLE_POS;
        active_pos[i] <= IDLE_POS;
      end
      pending <= '0;
      busy_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (transfer[i]) begin
          active_pos[i] <= stage_pos[i];
        end
        if (wr_hit[i]) begin
          stage_pos[i] <= DB[8:0];
        end
      end
      pending <= pending_nxt;
      // Registered from the next-state value so BUSY tracks the pending
      // bits on the same edge they change.
      busy_q  <= |pending_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Optional per-slot enable, staged and transferred alongside the position
  // --------------------------------------------------------------------------
`ifdef CMP_SLOT_ENABLE_EN
  logic [NUM_SLOTS-1:0] stage_en;
  logic [NUM_SLOTS-1:0] active_en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stage_en  <= '0;
      active_en <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (transfer[i]) begin
          active_en[i] <= stage_en[i];
        end
        if (wr_hit[i]) begin
          stage_en[i] <= DB[9];
        end
      end
    end
  end

  always_comb begin
    slot_en = active_en;
  end
`else
  // Enable bit is not stored in this build; every slot is always armed.
  logic unused_db_en;

  always_comb begin
    unused_db_en = DB[9];
    slot_en      = '1;
  end
`endif

  // --------------------------------------------------------------------------
  // Position counter with sticky clear request
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      clr_req <= 1'b0;
    end else begin
      if (PHI1) begin
        // A clear request arriving together with PHI1 is honoured in the
        // same update, never deferred to the following strobe.
        if (clr_req || CNT_CLR) begin
          cnt_q <= '0;
        end else if (cnt_q == HMAX) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 9'd1;
        end
        clr_req <= 1'b0;
      end else if (CNT_CLR) begin
        clr_req <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Evaluation and match pulse
  // --------------------------------------------------------------------------
  // eval is a plain delayed copy of PHI1: it is high for exactly the cycle
  // after each strobe, so back-to-back strobes each get their own evaluation
  // and a single strobe can never evaluate twice.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      eval <= 1'b0;
    end else begin
      eval <= PHI1;
    end
  end

  // Compared against post-update counter and active registers.
  always_comb begin
    match_nxt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      match_nxt[i] = eval && slot_en[i] && (active_pos[i] == cnt_q);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      match_q <= '0;
    end else begin
      match_q <= match_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign CNT   = cnt_q;
  assign MATCH = match_q;
  assign BUSY  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_nmos_cmp_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nmos_cmp_seq
//  Description : Self-checking bench for nmos_cmp_seq. Holds a behavioural
//                model of slots, counter and pending evaluation built from
//                the functional rules, and checks directed scenarios plus a
//                randomized run against it.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_nmos_cmp_seq;

  localparam int HMAX = 454;
`ifdef CMP_SLOT_ENABLE_EN
  localparam bit EN_BUILT = 1'b1;
`else
  localparam bit EN_BUILT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PHI1 = 1'b0;
  logic       WR_STB = 1'b0;
  logic [1:0] WR_ADDR = '0;
  logic [9:0] DB = '0;
  logic       CNT_CLR = 1'b0;
  logic [8:0] CNT;
  logic [3:0] MATCH;
  logic       BUSY;

  int errors = 0;
  int checks = 0;

  nmos_cmp_seq #(.HMAX(9'(HMAX))) dut (
    .CLK(CLK), .RST(RST), .PHI1(PHI1), .WR_STB(WR_STB), .WR_ADDR(WR_ADDR),
    .DB(DB), .CNT_CLR(CNT_CLR), .CNT(CNT), .MATCH(MATCH), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int       m_stage [4];
  int       m_active[4];
  bit       m_pend  [4];
  bit       m_sen   [4];
  bit       m_aen   [4];
  int       m_cnt;
  bit       m_clr;
  bit       m_eval_due;   // a strobe happened last cycle, evaluate now
  bit [3:0] m_match;
  bit       m_busy;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_stage[i] = 511; m_active[i] = 511; m_pend[i] = 0;
      m_sen[i] = 0; m_aen[i] = 0;
    end
    m_cnt = 0; m_clr = 0; m_eval_due = 0; m_match = '0; m_busy = 0;
  endfunction

  function automatic void model_step(bit phi, bit wr, bit [1:0] addr,
                                     bit [9:0] db, bit clr);
    m_match = '0;
    if (m_eval_due)
      for (int i = 0; i < 4; i++)
        m_match[i] = (m_active[i] == m_cnt) && (!EN_BUILT || m_aen[i]);
    if (phi) begin
      for (int i = 0; i < 4; i++)
        if (m_pend[i]) begin
          m_active[i] = m_stage[i]; m_aen[i] = m_sen[i]; m_pend[i] = 0;
        end
      if (m_clr || clr)      m_cnt = 0;
      else if (m_cnt == HMAX) m_cnt = 0;
      else                    m_cnt = m_cnt + 1;
      m_clr = 0;
    end else if (clr) begin
      m_clr = 1;
    end
    if (wr) begin
      m_stage[addr] = int'(db[8:0]); m_sen[addr] = db[9]; m_pend[addr] = 1;
    end
    m_eval_due = phi;
    m_busy = m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, sample #1 later.
  task automatic tick(input bit phi, input bit wr, input bit [1:0] addr,
                      input bit [9:0] db, input bit clr);
    PHI1 = phi; WR_STB = wr; WR_ADDR = addr; DB = db; CNT_CLR = clr;
    @(posedge CLK);
    model_step(phi, wr, addr, db, clr);
    #1;
    PHI1 = 0; WR_STB = 0; CNT_CLR = 0;
  endtask

  task automatic do_reset();
    RST = 1; PHI1 = 0; WR_STB = 0; CNT_CLR = 0; DB = '0; WR_ADDR = '0;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 0;
    model_reset();
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++; if (CNT !== 9'd0)   begin errors++; $display("FAIL reset_cnt got=%0d exp=0", CNT); end
    checks++; if (MATCH !== 4'd0) begin errors++; $display("FAIL reset_match got=%b exp=0000", MATCH); end
    checks++; if (BUSY !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
  endtask

  task automatic test_basic();
    int pulses = 0;
    do_reset();
    tick(0, 1, 2'd0, 10'h205, 0);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy_set got=%b exp=1", BUSY); end
    for (int p = 1; p <= 6; p++) begin
      tick(1, 0, 0, 0, 0);
      if (MATCH[0]) pulses++;
      if (p == 1) begin
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_clr got=%b exp=0", BUSY); end
      end
      tick(0, 0, 0, 0, 0);
      if (MATCH[0]) pulses++;
      checks++;
      if (MATCH[0] !== (p == 5)) begin
        errors++; $display("FAIL basic_match0 phi=%0d got=%b exp=%b", p, MATCH[0], (p == 5));
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL basic_pulse_count got=%0d exp=1", pulses); end
    checks++; if (CNT !== 9'd6) begin errors++; $display("FAIL basic_cnt got=%0d exp=6", CNT); end
  endtask

  task automatic test_coincident();
    do_reset();
    tick(1, 1, 2'd1, 10'h203, 0);               // CNT -> 1, write stays staged
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL coin_busy_hold got=%b exp=1", BUSY); end
    tick(0, 0, 0, 0, 0);
    checks++; if (MATCH !== 4'd0) begin errors++; $display("FAIL coin_no_match got=%b exp=0000", MATCH); end
    tick(1, 0, 0, 0, 0);                        // CNT -> 2, transfer
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL coin_busy_clr got=%b exp=0", BUSY); end
    tick(0, 0, 0, 0, 0);
    checks++; if (MATCH[1] !== 1'b0) begin errors++; $display("FAIL coin_match_cnt2 got=%b exp=0", MATCH[1]); end
    tick(1, 0, 0, 0, 0);                        // CNT -> 3
    tick(0, 0, 0, 0, 0);
    checks++; if (MATCH[1] !== 1'b1) begin errors++; $display("FAIL coin_match_cnt3 got=%b exp=1", MATCH[1]); end
  endtask

  task automatic test_wrap();
    int hi_pulses = 0;
    do_reset();
    tick(0, 1, 2'd0, 10'h200, 0);               // slot0 = 0
    tick(0, 1, 2'd1, 10'h3C7, 0);               // slot1 = 455
    tick(0, 1, 2'd2, 10'h3C6, 0);               // slot2 = 454
    for (int p = 1; p <= HMAX + 3; p++) begin
      tick(1, 0, 0, 0, 0);                      // back-to-back strobes
      if (MATCH[1]) hi_pulses++;
      checks++;
      if (CNT !== 9'(m_cnt) || MATCH !== m_match || BUSY !== m_busy) begin
        errors++;
        $display("FAIL wrap_model phi=%0d cnt=%0d/%0d match=%b/%b busy=%b/%b",
                 p, CNT, m_cnt, MATCH, m_match, BUSY, m_busy);
      end
      if (p == HMAX) begin
        checks++; if (CNT !== 9'(HMAX)) begin errors++; $display("FAIL wrap_at_hmax got=%0d exp=%0d", CNT, HMAX); end
      end
      if (p == HMAX + 1) begin
        checks++; if (CNT !== 9'd0) begin errors++; $display("FAIL wrap_to_zero got=%0d exp=0", CNT); end
        checks++; if (MATCH[2] !== 1'b1) begin errors++; $display("FAIL wrap_match_hmax got=%b exp=1", MATCH[2]); end
      end
      if (p == HMAX + 2) begin
        checks++; if (MATCH[0] !== 1'b1) begin errors++; $display("FAIL wrap_match_zero got=%b exp=1", MATCH[0]); end
      end
    end
    checks++; if (hi_pulses != 0) begin errors++; $display("FAIL wrap_455_never got=%0d exp=0", hi_pulses); end
  endtask

  task automatic test_clear();
    do_reset();
    repeat (100) tick(1, 0, 0, 0, 0);
    checks++; if (CNT !== 9'd100) begin errors++; $display("FAIL clr_pre got=%0d exp=100", CNT); end
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
    checks++; if (CNT !== 9'd100) begin errors++; $display("FAIL clr_hold got=%0d exp=100", CNT); end
    tick(1, 0, 0, 0, 0);
    checks++; if (CNT !== 9'd0) begin errors++; $display("FAIL clr_sticky got=%0d exp=0", CNT); end
    repeat (3) tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1);
    checks++; if (CNT !== 9'd0) begin errors++; $display("FAIL clr_coincident got=%0d exp=0", CNT); end
    tick(1, 0, 0, 0, 0);
    checks++; if (CNT !== 9'd1) begin errors++; $display("FAIL clr_consumed got=%0d exp=1", CNT); end
  endtask

  task automatic test_enable();
    int pulses = 0;
    do_reset();
    tick(0, 1, 2'd2, 10'h007, 0);
    repeat (7) begin tick(1, 0, 0, 0, 0); if (MATCH[2]) pulses++; end
    tick(0, 0, 0, 0, 0); if (MATCH[2]) pulses++;
    checks++;
    if (pulses != (EN_BUILT ? 0 : 1)) begin
      errors++; $display("FAIL en_disabled got=%0d exp=%0d", pulses, (EN_BUILT ? 0 : 1));
    end
    pulses = 0;
    tick(0, 1, 2'd2, 10'h207, 1);
    repeat (8) begin tick(1, 0, 0, 0, 0); if (MATCH[2]) pulses++; end
    tick(0, 0, 0, 0, 0); if (MATCH[2]) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL en_enabled got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(0, 1, 2'd3, 10'h202, 0);
    tick(1, 0, 0, 0, 0);                        // CNT 1, slot3 = 2 active
    tick(1, 1, 2'd0, 10'h201, 0);               // CNT 2 -> match scheduled
    RST = 1;                                    // asynchronous, mid-cycle
    #1;
    checks++; if (MATCH !== 4'd0) begin errors++; $display("FAIL rstmid_match got=%b exp=0000", MATCH); end
    checks++; if (CNT !== 9'd0)   begin errors++; $display("FAIL rstmid_cnt got=%0d exp=0", CNT); end
    checks++; if (BUSY !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got=%b exp=0", BUSY); end
    @(posedge CLK); #1;
    RST = 0;
    model_reset();
    tick(0, 0, 0, 0, 0);
    checks++; if (MATCH !== 4'd0) begin errors++; $display("FAIL rstmid_post_match got=%b exp=0000", MATCH); end
    tick(1, 0, 0, 0, 0);
    checks++; if (CNT !== 9'd1)   begin errors++; $display("FAIL rstmid_first_phi got=%0d exp=1", CNT); end
    tick(0, 0, 0, 0, 0);
    checks++; if (MATCH !== 4'd0) begin errors++; $display("FAIL rstmid_discard got=%b exp=0000", MATCH); end
  endtask

  task automatic test_random();
    bit       phi, wr, clr;
    bit [1:0] addr;
    bit [9:0] db;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      phi  = ($urandom_range(0, 2) == 0);
      wr   = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 19) == 0);
      addr = 2'($urandom_range(0, 3));
      db[9] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       db[8:0] = 9'h1FF;
        1:       db[8:0] = 9'($urandom_range(0, 511));
        default: db[8:0] = 9'($urandom_range(0, 12));
      endcase
      tick(phi, wr, addr, db, clr);
      checks++;
      if (CNT !== 9'(m_cnt) || MATCH !== m_match || BUSY !== m_busy) begin
        errors++;
        $display("FAIL rand_model n=%0d cnt=%0d/%0d match=%b/%b busy=%b/%b",
                 n, CNT, m_cnt, MATCH, m_match, BUSY, m_busy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_coincident();
    test_wrap();
    test_clear();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nmos_cmp_seq.md
NMOS_CMP_SEQ -- requirements
Module: nmos_cmp_seq

Interface
REQ-001 SHALL have parameter HMAX, default 9'd454, giving the last counter value before wrap; legal range 1..510.
REQ-002 SHALL have port CLK, input, 1 bit, the single main clock; all state is on the rising edge.
REQ-003 SHALL have port RST, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port PHI1, input, 1 bit, a phase-1 strobe, one CLK wide when active.
REQ-005 SHALL have port WR_STB, input, 1 bit, a phase-2 write request for one comparator slot.
REQ-006 SHALL have port WR_ADDR, input, 2 bits, selecting slot 0..3.
REQ-007 SHALL have port DB, input, 10 bits: [8:0] is the position; [9] is the slot enable (see REQ-025).
REQ-008 SHALL have port CNT_CLR, input, 1 bit, requesting a counter clear at the next PHI1.
REQ-009 SHALL have port CNT, output, 9 bits, the running position counter.
REQ-010 SHALL have port MATCH, output, 4 bits, giving a registered one-CLK match pulse per slot.
REQ-011 SHALL have port BUSY, output, 1 bit, high while any staged write awaits transfer.

Function
REQ-012 Four slots SHALL each hold a 9-bit stage register, a 9-bit active register and a pending bit.
REQ-013 A cycle with WR_STB=1 SHALL load DB[8:0] into stage[WR_ADDR] and set pending[WR_ADDR].
- Repeated writes to one slot before PHI1: last write wins.
- Writes to different slots: all remain pending.
REQ-014 On a PHI1 cycle, every pending slot SHALL copy stage to active, and its pending bit SHALL clear.
- Non-pending slots are unchanged.
REQ-015 When WR_STB and PHI1 coincide, the PHI1 transfer SHALL use the pre-write stage value.
- The new write stays pending until the next PHI1.
REQ-016 BUSY SHALL equal the OR of the four pending bits, registered.
REQ-017 CNT_CLR=1 SHALL set a sticky clear request; the next PHI1 consumes it.
- If CNT_CLR and PHI1 coincide, the request is consumed in that same cycle.
REQ-018 On each PHI1, CNT SHALL update as follows: clear request pending -> 0; else CNT==HMAX -> 0; else CNT+1. Between PHI1 strobes CNT holds.
REQ-019 An evaluate flag SHALL be set in the cycle after each PHI1 cycle.
- In that cycle, each slot's match is computed as (active[i]==CNT, post-update values), gated by REQ-025.
- MATCH[i] is driven high for exactly the following CLK and is 0 otherwise.
- PHI1 is one CLK wide and the registered evaluate flag clears every cycle, so at most one evaluation per PHI1.
REQ-020 Back-to-back PHI1 on consecutive cycles SHALL each produce their own evaluation, with no evaluation lost or merged.
REQ-021 Active value 9'h1FF SHALL never match, because CNT never exceeds HMAX<511.

Reset
REQ-022 RST=1 SHALL asynchronously apply: CNT=0; MATCH=0; BUSY=0; all pending bits=0; clear request=0; evaluate flag=0; all stage and active registers=9'h1FF; enable bits=0.
REQ-023 RST asserted mid-operation SHALL discard pending writes and any scheduled MATCH pulse; no MATCH is emitted in the first cycle after release.
REQ-024 After release, the first PHI1 SHALL drive CNT to 1 and the first MATCH can appear two cycles after that PHI1.

Configuration
REQ-025 Macro CMP_SLOT_ENABLE_EN SHALL select slot-enable handling.
- Defined: DB[9] is staged and transferred alongside the position; MATCH[i] requires the active enable bit = 1.
- Undefined: DB[9] is ignored, no enable storage is built, and all slots are always enabled.

Verification
REQ-026 Reset, write slot0=5 (DB=10'h205), six PHI1 strobes -> BUSY 1 then 0 after the first PHI1; MATCH[0] pulses once, the cycle after the fifth PHI1 (CNT=5).
REQ-027 WR_STB slot1=3 coincident with PHI1 -> active1 stays 9'h1FF; BUSY stays 1 until the next PHI1; after that PHI1, active1=3.
REQ-028 HMAX=454, run CNT to 454, then PHI1 -> CNT=0; a slot at 0 matches the cycle after that PHI1; a slot at 455 never matches.
REQ-029 CNT_CLR pulse at CNT=100 with no PHI1, then PHI1 -> CNT=0; CNT_CLR coincident with PHI1 -> CNT=0 in that same update.
REQ-030 With CMP_SLOT_ENABLE_EN defined, write slot2 DB=10'h007 (enable 0) -> no MATCH[2] at CNT=7; rewrite DB=10'h207 -> MATCH[2] at CNT=7. With the macro undefined, both writes match.
REQ-031 Assert RST the cycle after a PHI1 that would match -> MATCH stays 0, CNT=0, BUSY=0.
